// File: rtl/rv32i_types.sv
// Shared types for the memory-side blocks: cache arbiter state and grant encodings.
package rv32i_types;

    typedef enum logic [1:0] {
        IDLE,
        SERVE_I,
        SERVE_D,
        RECOVER
    } arb_state_t;

    typedef enum logic [1:0] {
        GRANT_NONE,
        GRANT_I,
        GRANT_D
    } arb_grant_t;

endpackage

// File: rtl/cache_arbiter.sv
// Shares the single pmem port between I-cache fills and D-cache fills/write-backs.
// D-cache wins by default; a streak limit guarantees a waiting I-cache fill gets through.
module cache_arbiter
    import rv32i_types::*;
#(
    parameter int LINE_WIDTH   = 256,
    parameter int ADDR_WIDTH   = 32,
    parameter int MAX_D_STREAK = 4
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  i_pmem_read,
    input  logic [ADDR_WIDTH-1:0] i_pmem_address,
    output logic [LINE_WIDTH-1:0] i_pmem_rdata,
    output logic                  i_pmem_resp,

    input  logic                  d_pmem_read,
    input  logic                  d_pmem_write,
    input  logic [ADDR_WIDTH-1:0] d_pmem_address,
    input  logic [LINE_WIDTH-1:0] d_pmem_wdata,
    output logic [LINE_WIDTH-1:0] d_pmem_rdata,
    output logic                  d_pmem_resp,

    output logic                  pmem_read,
    output logic                  pmem_write,
    output logic [ADDR_WIDTH-1:0] pmem_address,
    output logic [LINE_WIDTH-1:0] pmem_wdata,
    input  logic [LINE_WIDTH-1:0] pmem_rdata,
    input  logic                  pmem_resp
);

    localparam int SW = $clog2(MAX_D_STREAK + 1);
    localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_D_STREAK);

    arb_state_t    state;
    arb_grant_t    grant;
    logic [SW-1:0] d_streak;
    logic          d_req;

    assign d_req = d_pmem_read | d_pmem_write;

    // Only consulted in IDLE; the I-cache wins once D has used up its streak.
    always_comb begin
        grant = GRANT_NONE;
        if (d_req && !(i_pmem_read && d_streak == STREAK_MAX))
            grant = GRANT_D;
        else if (i_pmem_read)
            grant = GRANT_I;
    end

    assign i_pmem_rdata = pmem_rdata;
    assign d_pmem_rdata = pmem_rdata;
    assign i_pmem_resp  = (state == SERVE_I) && pmem_resp;
    assign d_pmem_resp  = (state == SERVE_D) && pmem_resp;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            d_streak     <= '0;
            pmem_read    <= 1'b0;
            pmem_write   <= 1'b0;
            pmem_address <= '0;
            pmem_wdata   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    case (grant)
                        GRANT_D: begin
                            state        <= SERVE_D;
                            pmem_address <= d_pmem_address;
                            pmem_wdata   <= d_pmem_wdata;
                            // Read+write together is illegal; the write wins.
                            pmem_write   <= d_pmem_write;
                            pmem_read    <= ~d_pmem_write;
                            if (d_streak != STREAK_MAX)
                                d_streak <= d_streak + 1'b1;
                        end
                        GRANT_I: begin
                            state        <= SERVE_I;
                            pmem_address <= i_pmem_address;
                            pmem_read    <= 1'b1;
                            d_streak     <= '0;
                        end
                        default: ;
                    endcase
                end
                SERVE_I, SERVE_D: begin
                    if (pmem_resp) begin
                        pmem_read  <= 1'b0;
                        pmem_write <= 1'b0;
                        state      <= RECOVER;
                    end
                end
                RECOVER: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    a_d_rw_exclusive: assert property (@(posedge clk) disable iff (rst)
        !(d_pmem_read && d_pmem_write));

endmodule

// File: tb/tb_cache_arbiter.sv
// Randomized bench for cache_arbiter: requester agents, a latency-randomized memory,
// and a negedge monitor that predicts every pmem grant from the arbitration rules.
module tb_cache_arbiter;

    localparam int LW   = 256;
    localparam int AW   = 32;
    localparam int MAXS = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          i_pmem_read = 1'b0;
    logic [AW-1:0] i_pmem_address = '0;
    logic [LW-1:0] i_pmem_rdata;
    logic          i_pmem_resp;
    logic          d_pmem_read = 1'b0;
    logic          d_pmem_write = 1'b0;
    logic [AW-1:0] d_pmem_address = '0;
    logic [LW-1:0] d_pmem_wdata = '0;
    logic [LW-1:0] d_pmem_rdata;
    logic          d_pmem_resp;
    logic          pmem_read;
    logic          pmem_write;
    logic [AW-1:0] pmem_address;
    logic [LW-1:0] pmem_wdata;
    logic [LW-1:0] pmem_rdata = '0;
    logic          pmem_resp = 1'b0;

    cache_arbiter #(.LINE_WIDTH(LW), .ADDR_WIDTH(AW), .MAX_D_STREAK(MAXS)) dut (
        .clk(clk), .rst(rst),
        .i_pmem_read(i_pmem_read), .i_pmem_address(i_pmem_address),
        .i_pmem_rdata(i_pmem_rdata), .i_pmem_resp(i_pmem_resp),
        .d_pmem_read(d_pmem_read), .d_pmem_write(d_pmem_write),
        .d_pmem_address(d_pmem_address), .d_pmem_wdata(d_pmem_wdata),
        .d_pmem_rdata(d_pmem_rdata), .d_pmem_resp(d_pmem_resp),
        .pmem_read(pmem_read), .pmem_write(pmem_write),
        .pmem_address(pmem_address), .pmem_wdata(pmem_wdata),
        .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string nm, input bit ok, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic logic [LW-1:0] rnd_line();
        logic [LW-1:0] v;
        for (int k = 0; k < LW / 32; k++) v[k*32 +: 32] = $urandom;
        return v;
    endfunction

    // Memory: random 0..5 cycle latency per strobe, occasional spurious resp when idle.
    bit mem_hold = 1'b0;
    initial begin
        int cnt;
        cnt = -1;
        forever begin
            @(posedge clk); #1;
            pmem_resp  = 1'b0;
            pmem_rdata = rnd_line();
            if (rst || mem_hold) begin
                cnt = -1;
            end else if (pmem_read || pmem_write) begin
                if (cnt < 0) cnt = int'($urandom_range(0, 5));
                if (cnt == 0) begin
                    pmem_resp = 1'b1;
                    cnt = -1;
                end else cnt--;
            end else begin
                cnt = -1;
                if ($urandom_range(0, 9) == 0) pmem_resp = 1'b1;
            end
        end
    end

    // Reference: one line transaction at a time, decided only in idle cycles
    // (two cycles after the previous completion), D first unless I has waited out MAXS D grants.
    typedef struct {
        bit            is_d;
        bit            wr;
        logic [AW-1:0] addr;
        logic [LW-1:0] wdata;
    } txn_t;

    txn_t exp_q[$];
    txn_t cur;
    bit   busy = 1'b0;
    int   cyc = 0;
    int   resp_cyc = -100;
    int   streak = 0;

    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (rst) begin
                chk("rst_pmem_read", pmem_read == 1'b0, LW'(pmem_read), 0);
                chk("rst_pmem_write", pmem_write == 1'b0, LW'(pmem_write), 0);
                chk("rst_pmem_address", pmem_address == '0, LW'(pmem_address), 0);
                chk("rst_pmem_wdata", pmem_wdata == '0, pmem_wdata, 0);
                chk("rst_resps", !i_pmem_resp && !d_pmem_resp, LW'({i_pmem_resp, d_pmem_resp}), 0);
                exp_q.delete();
                busy = 1'b0;
                streak = 0;
                resp_cyc = -100;
            end else begin
                chk("rdata_pass", i_pmem_rdata === pmem_rdata && d_pmem_rdata === pmem_rdata,
                    i_pmem_rdata, pmem_rdata);
                if (!busy && exp_q.size() > 0) begin
                    cur = exp_q.pop_front();
                    busy = 1'b1;
                end
                if (busy) begin
                    chk("pmem_read", pmem_read === !cur.wr, LW'(pmem_read), LW'(!cur.wr));
                    chk("pmem_write", pmem_write === cur.wr, LW'(pmem_write), LW'(cur.wr));
                    chk("pmem_address", pmem_address === cur.addr, LW'(pmem_address), LW'(cur.addr));
                    if (cur.wr) chk("pmem_wdata", pmem_wdata === cur.wdata, pmem_wdata, cur.wdata);
                    chk("i_resp", i_pmem_resp === (pmem_resp && !cur.is_d),
                        LW'(i_pmem_resp), LW'(pmem_resp && !cur.is_d));
                    chk("d_resp", d_pmem_resp === (pmem_resp && cur.is_d),
                        LW'(d_pmem_resp), LW'(pmem_resp && cur.is_d));
                    if (pmem_resp) begin
                        busy = 1'b0;
                        resp_cyc = cyc;
                    end
                end else begin
                    chk("idle_no_strobe", !pmem_read && !pmem_write, LW'({pmem_read, pmem_write}), 0);
                    chk("idle_no_resp", !i_pmem_resp && !d_pmem_resp, LW'({i_pmem_resp, d_pmem_resp}), 0);
                end
                if (!busy && exp_q.size() == 0 && cyc >= resp_cyc + 2 &&
                    (i_pmem_read || d_pmem_read || d_pmem_write)) begin
                    txn_t t;
                    if ((d_pmem_read || d_pmem_write) && !(i_pmem_read && streak == MAXS)) begin
                        t.is_d  = 1'b1;
                        t.wr    = d_pmem_write;
                        t.addr  = d_pmem_address;
                        t.wdata = d_pmem_wdata;
                        if (streak < MAXS) streak++;
                    end else begin
                        t.is_d  = 1'b0;
                        t.wr    = 1'b0;
                        t.addr  = i_pmem_address;
                        t.wdata = '0;
                        streak  = 0;
                    end
                    exp_q.push_back(t);
                end
            end
        end
    end

    task automatic i_req(input logic [AW-1:0] a);
        int t;
        t = 0;
        @(posedge clk); #1;
        i_pmem_address = a;
        i_pmem_read    = 1'b1;
        do begin
            @(negedge clk);
            t++;
        end while (!i_pmem_resp && t < 400);
        if (!i_pmem_resp) chk("i_timeout", 1'b0, LW'(t), 400);
        @(posedge clk); #1;
        i_pmem_read = 1'b0;
    endtask

    // Optionally scrambles address/wdata while waiting; only the value seen at grant may reach pmem.
    task automatic d_req(input logic [AW-1:0] a, input bit wr, input logic [LW-1:0] wd, input bit scramble);
        int t;
        t = 0;
        @(posedge clk); #1;
        d_pmem_address = a;
        d_pmem_wdata   = wd;
        d_pmem_read    = !wr;
        d_pmem_write   = wr;
        forever begin
            @(negedge clk);
            t++;
            if (d_pmem_resp || t >= 400) break;
            @(posedge clk); #1;
            if (scramble && $urandom_range(0, 3) == 0) begin
                d_pmem_address = $urandom;
                d_pmem_wdata   = rnd_line();
            end
        end
        if (!d_pmem_resp) chk("d_timeout", 1'b0, LW'(t), 400);
        @(posedge clk); #1;
        d_pmem_read  = 1'b0;
        d_pmem_write = 1'b0;
    endtask

    task automatic i_agent(input int n, input int gmax);
        for (int k = 0; k < n; k++) begin
            repeat ($urandom_range(0, gmax)) @(posedge clk);
            i_req($urandom & ~32'h1f);
        end
    endtask

    task automatic d_agent(input int n, input int gmax);
        for (int k = 0; k < n; k++) begin
            repeat ($urandom_range(0, gmax)) @(posedge clk);
            d_req($urandom & ~32'h1f, 1'($urandom_range(0, 1)), rnd_line(), 1'b1);
        end
    endtask

    initial begin
        int t;
        repeat (3) @(negedge clk);
        #1 rst = 1'b0;

        i_req(32'h0000_1000);
        fork
            i_req(32'h0000_3000);
            d_req(32'h0000_2000, 1'b1, {32{8'hA5}}, 1'b0);
        join

        fork
            i_agent(30, 4);
            d_agent(30, 4);
        join
        // Saturating contention: D back-to-back with I pending.
        fork
            i_agent(6, 0);
            d_agent(30, 0);
        join
        repeat (4) @(posedge clk);

        // Asynchronous reset while an I fill is outstanding.
        mem_hold = 1'b1;
        @(posedge clk); #1;
        i_pmem_address = 32'h0000_4000;
        i_pmem_read    = 1'b1;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!pmem_read && t < 20);
        chk("rst_test_grant", pmem_read, LW'(pmem_read), 1);
        #1 rst = 1'b1;
        #1;
        chk("async_rst_read", pmem_read == 1'b0, LW'(pmem_read), 0);
        chk("async_rst_addr", pmem_address == '0, LW'(pmem_address), 0);
        chk("async_rst_resp", !i_pmem_resp && !d_pmem_resp, LW'({i_pmem_resp, d_pmem_resp}), 0);
        i_pmem_read = 1'b0;
        mem_hold = 1'b0;
        repeat (2) @(negedge clk);
        #1 rst = 1'b0;

        i_req(32'h0000_5000);
        d_req(32'h0000_6000, 1'b0, '0, 1'b1);
        repeat (6) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cache_arbiter.md
Name: cache_arbiter

Overview:
- Shares the single physical-memory port between the instruction-cache and data-cache miss paths.
- Sits between the two cache_control/datapath pairs and pmem.
- Grants one whole line transaction (read fill or write-back) at a time.
- D-cache has fixed priority, bounded by a streak limit so that I-cache fills cannot starve.

Parameters:
- LINE_WIDTH, 256, bits per cache line / pmem burst payload.
- ADDR_WIDTH, 32, physical address width.
- MAX_D_STREAK, 4, max consecutive D grants while I is waiting; must be ≥1.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- i_pmem_read  in  1  I-cache line-fill request; level, held until i_pmem_resp.
- i_pmem_address  in  ADDR_WIDTH  I-cache line address.
- i_pmem_rdata  out  LINE_WIDTH  fill data to I-cache.
- i_pmem_resp  out  1  one-cycle completion pulse to I-cache.
- d_pmem_read  in  1  D-cache line-fill request; level.
- d_pmem_write  in  1  D-cache write-back request; level.
- d_pmem_address  in  ADDR_WIDTH  D-cache line address.
- d_pmem_wdata  in  LINE_WIDTH  write-back data.
- d_pmem_rdata  out  LINE_WIDTH  fill data to D-cache.
- d_pmem_resp  out  1  one-cycle completion pulse to D-cache.
- pmem_read  out  1  memory read strobe.
- pmem_write  out  1  memory write strobe.
- pmem_address  out  ADDR_WIDTH  memory address.
- pmem_wdata  out  LINE_WIDTH  memory write data.
- pmem_rdata  in  LINE_WIDTH  memory read data.
- pmem_resp  in  1  memory completion pulse.

Behaviour:
- States:
  - IDLE: no transaction.
  - SERVE_I: I-cache read in flight.
  - SERVE_D: D-cache read or write in flight.
  - RECOVER: 1-cycle turnaround so the requester drops its level request after resp.
- Reset (async, any state): state=IDLE, d_streak=0.
  - All registered outputs 0: pmem_read, pmem_write, pmem_address, pmem_wdata.
  - i_pmem_resp = d_pmem_resp = 0.
  - Any in-flight pmem transaction is abandoned; the memory model is reset by the same rst.
- IDLE arbitration (let d_req = d_pmem_read|d_pmem_write):
  - d_req and not (i_pmem_read and d_streak==MAX_D_STREAK) → SERVE_D, d_streak++ (saturating).
  - Otherwise, i_pmem_read → SERVE_I, d_streak=0.
  - Neither → stay IDLE.
- Grant registration: on the IDLE→SERVE_x edge, latch the winner's address/wdata and assert pmem_read or pmem_write.
  - First pmem strobe appears the cycle after the request is seen (1-cycle grant latency).
  - Latched values are held constant for the whole transaction, independent of requester-side changes.
- d_pmem_read & d_pmem_write both high: protocol violation. Treated as write; simulation assertion fires.
- SERVE_x on pmem_resp:
  - Deassert pmem strobes.
  - Pulse the matching x_pmem_resp combinationally in the same cycle; the other resp stays 0.
  - Go to RECOVER.
  - Both x_pmem_rdata outputs equal pmem_rdata at all times; only resp qualifies the data.
- RECOVER → IDLE unconditionally. Requests visible in RECOVER are ignored; the next grant is decided in IDLE.
  - Back-to-back turnaround: resp cycle + RECOVER + IDLE decision = new strobe 3 cycles after the previous pmem_resp.
- pmem_resp outside SERVE_x is ignored; no resp is forwarded.
- Requester dropping its request mid-transaction is illegal. The transaction still completes; resp is still pulsed.
- No combinational path from any request input to pmem_* outputs.

Decomposition:
- Shared package rv32i_types gains:
  - arb_state_t enum {IDLE, SERVE_I, SERVE_D, RECOVER}.
  - arb_grant_t enum {GRANT_NONE, GRANT_I, GRANT_D}.
- No sub-module; the streak counter is a few lines inline. Single module, roughly 150-200 lines.

Test Plan:
- Lone I read, addr 0x0000_1000, pmem_resp after 5 cycles → pmem_read=1 with that address from cycle 1; i_pmem_resp one pulse with rdata; d_pmem_resp stays 0.
- I read and D write (addr 0x0000_2000, wdata=0xA5 repeated) asserted in the same cycle → D served first with pmem_write; I served after RECOVER+IDLE, 3 cycles after D's resp.
- D requests continuously (read, MAX_D_STREAK=4) while I held high → exactly 4 D grants, then 1 I grant, then d_streak restarts at 0.
- Change d_pmem_address mid-SERVE_D → pmem_address remains the latched value until resp.
- Assert rst mid-SERVE_I → same cycle (async): pmem_read=0, state IDLE; after release a fresh I request is granted normally.
- Spurious pmem_resp in IDLE → no i/d resp pulse, state unchanged.
